int_arbiter: RTL and testbench
==============================

Name: int_arbiter

Overview:
- Memory-mapped priority interrupt controller between the peripherals (UART, LED4, and future sources) and the CPU interrupt inputs.
- Latches rising-edge requests from N sources and applies a software mask.
- Selects the highest-priority pending source, drives the CPU int_req, int_en and int_vec, and sequences request, acknowledge, service and end-of-interrupt (EOI).
- Registers sit on the CPU data bus: rs_data as address, rd_data as write data, mem_w_en as write strobe.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- MASK_ADDR, 8'd247, mask register address, R/W.
- PEND_ADDR, 8'd246, pending register address; read returns pending, write is write-1-to-clear.
- EOI_ADDR, 8'd245, write with any data signals EOI; read returns status.
- VEC_ADDR, 8'd250, vector base register address, R/W.
- VEC_STRIDE, 4, vector spacing per source id.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- src_req  in  N_SRC  source request lines; bit 0 is highest priority.
- addr  in  8  bus address (rs_data).
- w_data  in  8  bus write data (rd_data).
- w_en  in  1  bus write strobe (mem_w_en).
- r_data  out  8  combinational read data for addr.
- r_hit  out  1  combinational; 1 when addr matches one of the four register addresses.
- int_ack  in  1  one-cycle pulse from the CPU when it vectors into the handler.
- int_req  out  1  interrupt request to the CPU.
- int_en  out  8  8'h01 = CPU may take an interrupt; 8'h00 = in service.
- int_vec  out  8  handler address for the active source.
- active_id  out  3  id of the source being requested or serviced.

Behaviour:
- Reset (rst_n=0 at a clock edge), all registered:
  - mask=0, pending=0, vec_base=0, src_prev=0, state=IDLE.
  - int_req=0, int_en=8'h01, int_vec=0, active_id=0.
  - A source held high across reset release counts as an edge.
- Edge capture:
  - pending[i] is set when src_req[i]=1 and src_prev[i]=0; src_prev is updated every cycle.
  - Capture happens regardless of mask.
- Pending clear paths:
  - W1C write to PEND_ADDR clears the bits written as 1.
  - int_ack clears pending[active_id].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Eligible = pending & mask. Priority is fixed: the lowest index wins.
- Vector: int_vec = vec_base + active_id*VEC_STRIDE, truncated to 8 bits (wraps mod 256). It is latched at grant and does not track later vec_base writes.
- State machine:
  - IDLE:
    - If eligible != 0: latch active_id and int_vec, set int_req<=1, go to REQ.
    - Otherwise stay in IDLE.
  - REQ (int_req=1, int_en=8'h01):
    - int_ack=1: int_req<=0, int_en<=8'h00, clear pending[active_id], go to SERVICE.
    - Otherwise, if mask[active_id]=0 (software masked it): int_req<=0, go to IDLE, pending stays set.
    - int_ack takes precedence over a mask withdraw in the same cycle.
    - A higher-priority source arriving during REQ does not preempt.
  - SERVICE (int_req=0, int_en=8'h00):
    - w_en=1 with addr=EOI_ADDR: int_en<=8'h01, go to IDLE.
    - New edges keep latching into pending.
  - There is no re-arbitration in the EOI cycle. A pending request is re-granted one cycle after IDLE is entered, so int_req is low for at least one cycle between services.
- int_ack outside REQ is ignored. EOI outside SERVICE is ignored.
- Latency: src_req first sampled high at edge t → pending visible after t → int_req high after edge t+1 (2 cycles).
- Register reads (combinational):
  - MASK_ADDR returns {0, mask}.
  - PEND_ADDR returns {0, pending}.
  - VEC_ADDR returns vec_base.
  - EOI_ADDR returns {state[1:0], 3'b0, active_id}, with IDLE=00, REQ=01, SERVICE=10.
- Bits at or above N_SRC read as 0 and ignore writes.
- Any other address: r_hit=0, r_data=0.
- Register writes take effect at the clock edge in which w_en=1 with a matching addr.

Test Plan:
- Reset, then mask=4'hF, vec_base=8'h40; pulse src_req[2] → int_req=1 two cycles later; int_vec=8'h48; active_id=2.
- src_req[1] and src_req[3] rise in the same cycle → grant id 1 (int_vec=8'h44); int_ack → pending=4'b1000, int_en=8'h00; EOI → one idle cycle, then grant id 3 (int_vec=8'h4C).
- vec_base=8'hFC, pulse src 1 → int_vec=8'h00 (wrap).
- In REQ for id 0, write mask=4'hE → int_req drops next cycle, state=IDLE, pending[0] still 1; rewrite mask=4'hF → re-request id 0.
- During SERVICE for id 2, pulse src 2 again → pending[2]=1; EOI → re-grant id 2. W1C write 8'h04 in the same cycle as a new src 2 edge → pending[2] stays 1.
- Assert rst_n=0 mid-SERVICE → next edge shows int_req=0, int_en=8'h01, pending=0, mask=0.

Source files
------------

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt controller: latches source edges, masks, grants the lowest pending id to the CPU.
// Latency: src_req edge sampled at edge t -> pending after t -> int_req after edge t+1.
// Backpressure: a granted request is held in REQ until int_ack or mask withdraw; service blocks new grants until EOI.
// Ports: clock/rst_n (sync, active-low); src_req edge inputs; addr/w_data/w_en/r_data/r_hit register bus;
//        int_ack from CPU; int_req/int_en/int_vec/active_id to CPU.
module int_arbiter #(
   parameter int         N_SRC      = 4,
   parameter logic [7:0] MASK_ADDR  = 8'd247,
   parameter logic [7:0] PEND_ADDR  = 8'd246,
   parameter logic [7:0] EOI_ADDR   = 8'd245,
   parameter logic [7:0] VEC_ADDR   = 8'd250,
   parameter int         VEC_STRIDE = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src_req,
   input  logic [7:0]       addr,
   input  logic [7:0]       w_data,
   input  logic             w_en,
   output logic [7:0]       r_data,
   output logic             r_hit,
   input  logic             int_ack,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec,
   output logic [2:0]       active_id
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_SERVICE = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   src_prev_q, src_prev_d;
   logic [7:0]         vec_base_q, vec_base_d;
   logic               int_req_q, int_req_d;
   logic [7:0]         int_en_q, int_en_d;
   logic [7:0]         int_vec_q, int_vec_d;
   logic [2:0]         active_id_q, active_id_d;

   logic               wr_mask, wr_pend, wr_eoi, wr_vec;
   logic [N_SRC-1:0]   rise, pend_clr, eligible, active_oh;
   logic [2:0]         grant_id;
   logic [7:0]         grant_vec;

   assign wr_mask = w_en && (addr == MASK_ADDR);
   assign wr_pend = w_en && (addr == PEND_ADDR);
   assign wr_eoi  = w_en && (addr == EOI_ADDR);
   assign wr_vec  = w_en && (addr == VEC_ADDR);

   assign rise     = src_req & ~src_prev_q;
   assign eligible = pending_q & mask_q;

   // Lowest index wins: scan downward so the last hit is the smallest id.
   always_comb begin
      grant_id = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) grant_id = 3'(i);
      end
   end

   // Vector wraps modulo 256 by truncation.
   assign grant_vec = vec_base_q + 8'(int'(grant_id) * VEC_STRIDE);

   // One-hot of the active id, avoids indexing an N_SRC vector with a 3-bit id.
   always_comb begin
      active_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         active_oh[i] = (active_id_q == 3'(i));
      end
   end

   always_comb begin
      state_d     = state_q;
      int_req_d   = int_req_q;
      int_en_d    = int_en_q;
      int_vec_d   = int_vec_q;
      active_id_d = active_id_q;
      src_prev_d  = src_req;
      mask_d      = wr_mask ? w_data[N_SRC-1:0] : mask_q;
      vec_base_d  = wr_vec  ? w_data : vec_base_q;
      pend_clr    = wr_pend ? w_data[N_SRC-1:0] : '0;

      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               active_id_d = grant_id;
               int_vec_d   = grant_vec;
               int_req_d   = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack beats a simultaneous mask withdraw.
            if (int_ack) begin
               int_req_d = 1'b0;
               int_en_d  = 8'h00;
               pend_clr  = pend_clr | active_oh;
               state_d   = ST_SERVICE;
            end else if (!(|(mask_q & active_oh))) begin
               // Software masked the active source: withdraw, leave it pending.
               int_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (wr_eoi) begin
               int_en_d = 8'h01;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            int_req_d = 1'b0;
            int_en_d  = 8'h01;
            state_d   = ST_IDLE;
         end
      endcase

      // A new edge wins over any clear of the same bit.
      pending_d = (pending_q & ~pend_clr) | rise;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mask_q      <= '0;
         pending_q   <= '0;
         src_prev_q  <= '0;
         vec_base_q  <= 8'h00;
         int_req_q   <= 1'b0;
         int_en_q    <= 8'h01;
         int_vec_q   <= 8'h00;
         active_id_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         pending_q   <= pending_d;
         src_prev_q  <= src_prev_d;
         vec_base_q  <= vec_base_d;
         int_req_q   <= int_req_d;
         int_en_q    <= int_en_d;
         int_vec_q   <= int_vec_d;
         active_id_q <= active_id_d;
      end
   end

   always_comb begin
      r_hit  = 1'b1;
      r_data = 8'h00;
      if (addr == MASK_ADDR)      r_data = 8'(mask_q);
      else if (addr == PEND_ADDR) r_data = 8'(pending_q);
      else if (addr == VEC_ADDR)  r_data = vec_base_q;
      else if (addr == EOI_ADDR)  r_data = {state_q, 3'b000, active_id_q};
      else                        r_hit  = 1'b0;
   end

   assign int_req   = int_req_q;
   assign int_en    = int_en_q;
   assign int_vec   = int_vec_q;
   assign active_id = active_id_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: grant, priority, vector wrap, mask withdraw, re-pend, W1C vs edge, reset.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// All expected values are hand-computed constants.
module tb_int_arbiter;

   localparam logic [7:0] MASK_A = 8'd247;
   localparam logic [7:0] PEND_A = 8'd246;
   localparam logic [7:0] EOI_A  = 8'd245;
   localparam logic [7:0] VEC_A  = 8'd250;

   logic       clock = 1'b0;
   logic       rst_n;
   logic [3:0] src_req;
   logic [7:0] addr, w_data;
   logic       w_en;
   logic [7:0] r_data;
   logic       r_hit;
   logic       int_ack;
   logic       int_req;
   logic [7:0] int_en, int_vec;
   logic [2:0] active_id;

   int n_checks = 0;
   int n_errors = 0;

   int_arbiter dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .src_req   (src_req),
      .addr      (addr),
      .w_data    (w_data),
      .w_en      (w_en),
      .r_data    (r_data),
      .r_hit     (r_hit),
      .int_ack   (int_ack),
      .int_req   (int_req),
      .int_en    (int_en),
      .int_vec   (int_vec),
      .active_id (active_id)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr   = a;
      w_data = d;
      w_en   = 1'b1;
      tick();
      w_en   = 1'b0;
      addr   = 8'h00;
      w_data = 8'h00;
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk(tag, r_data, exp);
      addr = 8'h00;
   endtask

   task automatic pulse(input logic [3:0] s);
      src_req = s;
      tick();
      src_req = 4'h0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      src_req = 4'h0;
      addr    = 8'h00;
      w_data  = 8'h00;
      w_en    = 1'b0;
      int_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      chk("rst_int_req", int_req, 0);
      chk("rst_int_en", int_en, 8'h01);
      chk("rst_int_vec", int_vec, 8'h00);
      chk("rst_active_id", active_id, 0);
      chk_rd("rst_mask", MASK_A, 8'h00);
      chk_rd("rst_status", EOI_A, 8'h00);
      addr = 8'h10;
      #1;
      chk("miss_r_hit", r_hit, 0);
      chk("miss_r_data", r_data, 8'h00);
      addr = EOI_A;
      #1;
      chk("eoi_r_hit", r_hit, 1);
      addr = 8'h00;

      // ack outside REQ is ignored
      ack();
      chk("idle_ack_int_en", int_en, 8'h01);

      // Single source grant
      wr(MASK_A, 8'hFF);
      wr(VEC_A, 8'h40);
      chk_rd("mask_rb", MASK_A, 8'h0F);
      chk_rd("vec_rb", VEC_A, 8'h40);
      pulse(4'b0100);
      chk_rd("t1_pend", PEND_A, 8'h04);
      chk("t1_req_early", int_req, 0);
      tick();
      chk("t1_int_req", int_req, 1);
      chk("t1_int_vec", int_vec, 8'h48);
      chk("t1_active", active_id, 2);
      chk_rd("t1_status", EOI_A, 8'h42);
      ack();
      chk("t1_ack_req", int_req, 0);
      chk("t1_ack_en", int_en, 8'h00);
      chk_rd("t1_ack_pend", PEND_A, 8'h00);
      wr(EOI_A, 8'h00);
      chk("t1_eoi_en", int_en, 8'h01);
      tick();
      chk("t1_idle_req", int_req, 0);

      // Simultaneous sources: lowest id wins, the other waits
      pulse(4'b1010);
      tick();
      chk("t2_active", active_id, 1);
      chk("t2_int_vec", int_vec, 8'h44);
      ack();
      chk_rd("t2_pend", PEND_A, 8'h08);
      chk("t2_int_en", int_en, 8'h00);
      chk_rd("t2_status", EOI_A, 8'h81);
      wr(EOI_A, 8'h5A);
      chk("t2_gap_req", int_req, 0);
      tick();
      chk("t2_regrant_req", int_req, 1);
      chk("t2_regrant_id", active_id, 3);
      chk("t2_regrant_vec", int_vec, 8'h4C);
      ack();
      wr(EOI_A, 8'h00);

      // Vector wrap
      wr(VEC_A, 8'hFC);
      pulse(4'b0010);
      tick();
      chk("t3_int_req", int_req, 1);
      chk("t3_int_vec", int_vec, 8'h00);
      ack();
      wr(EOI_A, 8'h00);
      wr(VEC_A, 8'h40);

      // Mask withdraw while in REQ
      pulse(4'b0001);
      tick();
      chk("t4_req", int_req, 1);
      chk("t4_active", active_id, 0);
      wr(MASK_A, 8'h0E);
      chk("t4_req_hold", int_req, 1);
      tick();
      chk("t4_withdraw", int_req, 0);
      chk_rd("t4_status", EOI_A, 8'h00);
      chk_rd("t4_pend", PEND_A, 8'h01);
      wr(MASK_A, 8'h0F);
      chk("t4_no_grant_yet", int_req, 0);
      tick();
      chk("t4_rerequest", int_req, 1);
      chk("t4_re_id", active_id, 0);
      ack();
      wr(EOI_A, 8'h00);

      // Re-pend during service, then W1C racing an edge
      pulse(4'b0100);
      tick();
      ack();
      pulse(4'b0100);
      chk_rd("t5_repend", PEND_A, 8'h04);
      chk("t5_in_service", int_en, 8'h00);
      chk("t5_no_req", int_req, 0);
      wr(EOI_A, 8'h00);
      tick();
      chk("t5_regrant", int_req, 1);
      chk("t5_regrant_id", active_id, 2);
      src_req = 4'b0100;
      addr    = PEND_A;
      w_data  = 8'h04;
      w_en    = 1'b1;
      tick();
      w_en    = 1'b0;
      addr    = 8'h00;
      src_req = 4'h0;
      chk_rd("t5_set_wins", PEND_A, 8'h04);
      wr(PEND_A, 8'h04);
      chk_rd("t5_w1c", PEND_A, 8'h00);
      ack();
      chk("t5_service", int_en, 8'h00);

      // Reset mid-service, with src 3 held high across release
      src_req = 4'b1000;
      tick();
      rst_n = 1'b0;
      tick();
      chk("t6_int_req", int_req, 0);
      chk("t6_int_en", int_en, 8'h01);
      chk("t6_active", active_id, 0);
      chk_rd("t6_pend", PEND_A, 8'h00);
      chk_rd("t6_mask", MASK_A, 8'h00);
      rst_n = 1'b1;
      tick();
      chk_rd("t6_held_edge", PEND_A, 8'h08);
      chk("t6_masked_no_req", int_req, 0);
      src_req = 4'h0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
